// File: rtl/choice_predictor_param.sv
// Tournament choice predictor: a table of saturating counters picks lp or gp per branch.
// The table is swept to INIT_VAL after reset; lookups see same-edge updates through a bypass.
module choice_predictor_param #(
  parameter int HIST_W    = 12,
  parameter int PC_W      = 12,
  parameter int CTR_W     = 3,
  parameter int HASH_MODE = 0,
  parameter int INIT_VAL  = 2**(CTR_W-1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              lookup_valid,
  input  logic [HIST_W-1:0] lookup_history,
  input  logic [PC_W-1:0]   lookup_pc,
  input  logic              lp_prediction,
  input  logic              gp_prediction,
  output logic              pred_valid,
  output logic              choice_prediction,
  output logic              final_prediction,
  output logic [HIST_W-1:0] pred_index,
  input  logic              update_valid,
  input  logic [HIST_W-1:0] update_index,
  input  logic              update_lp,
  input  logic              update_gp,
  input  logic              actually_taken
);

  localparam int                DEPTH    = 1 << HIST_W;
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(INIT_VAL);
  localparam logic [HIST_W-1:0] LAST_IDX = HIST_W'(DEPTH - 1);
  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  logic [0:0]        state_q;
  logic [HIST_W-1:0] sweep_ptr;
  logic [CTR_W-1:0]  table_q [DEPTH];

  logic              run_p0;
  logic [HIST_W-1:0] idx_p0;
  logic [CTR_W-1:0]  upd_cur_p0;
  logic [CTR_W-1:0]  upd_new_p0;
  logic              cnt_up_p0;
  logic              cnt_dn_p0;
  logic              upd_we_p0;
  logic [CTR_W-1:0]  lkp_ctr_p0;
  logic              choice_p0;

  logic              vld_p1;
  logic              choice_p1;
  logic              final_p1;
  logic [HIST_W-1:0] idx_p1;

  logic              unused_pc;
  assign unused_pc = ^lookup_pc;

  generate
    if (HASH_MODE != 0) begin : g_hash
      assign idx_p0 = lookup_history ^ lookup_pc[HIST_W-1:0];
    end else begin : g_direct
      assign idx_p0 = lookup_history;
    end
  endgenerate

  // ---- stage p0: table read, update arithmetic, same-index bypass ----
  assign run_p0     = (state_q == ST_RUN);
  assign upd_cur_p0 = table_q[update_index];
  assign cnt_up_p0  = (update_gp == actually_taken) && (update_lp != actually_taken);
  assign cnt_dn_p0  = (update_lp == actually_taken) && (update_gp != actually_taken);
  assign upd_new_p0 = cnt_up_p0 ? sat_inc(upd_cur_p0) :
                      cnt_dn_p0 ? sat_dec(upd_cur_p0) : upd_cur_p0;
  assign upd_we_p0  = run_p0 && update_valid && (cnt_up_p0 || cnt_dn_p0);

  assign lkp_ctr_p0 = (upd_we_p0 && (update_index == idx_p0)) ? upd_new_p0 : table_q[idx_p0];
  assign choice_p0  = (lkp_ctr_p0 >= CTR_INIT);

  // Counter storage carries no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clock) begin
    if (!run_p0) begin
      table_q[sweep_ptr] <= CTR_INIT;
    end else if (upd_we_p0) begin
      table_q[update_index] <= upd_new_p0;
    end
  end

  // ---- stage p1: registered prediction and init sweep control ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      sweep_ptr <= '0;
      vld_p1    <= 1'b0;
      choice_p1 <= 1'b0;
      final_p1  <= 1'b0;
      idx_p1    <= '0;
    end else if (state_q == ST_INIT) begin
      sweep_ptr <= sweep_ptr + HIST_W'(1);
      vld_p1    <= 1'b0;
      if (sweep_ptr == LAST_IDX) begin
        state_q <= ST_RUN;
      end
    end else begin
      vld_p1 <= lookup_valid;
      if (lookup_valid) begin
        idx_p1    <= idx_p0;
        choice_p1 <= choice_p0;
        final_p1  <= choice_p0 ? gp_prediction : lp_prediction;
      end
    end
  end

  assign ready             = (state_q == ST_RUN);
  assign pred_valid        = vld_p1;
  assign choice_prediction = choice_p1;
  assign final_prediction  = final_p1;
  assign pred_index        = idx_p1;

endmodule

// File: doc/choice_predictor_param.md
Name: choice_predictor_param

Overview:
Parametrised tournament choice predictor. It selects between the local predictor (lp) and the global predictor (gp) through a table of saturating counters indexed by global history, optionally hashed with PC. Versus the fixed 12-bit/3-bit choice predictor it adds:
- explicit lookup/update ports with a returned index;
- a registered prediction with same-cycle write bypass;
- an FSM that sweeps the table to its initial value after reset.

It sits beside the lp/gp predictors in the Tournament front end.

Parameters:
HIST_W, 12, global-history/index width; table depth DEPTH = 2**HIST_W; legal range 4..16.
PC_W, 12, lookup_pc width; must be >= HIST_W when HASH_MODE=1.
CTR_W, 3, counter width; legal range 2..4.
HASH_MODE, 0, 0 = index is history; 1 = index is history XOR pc[HIST_W-1:0] (gshare style).
INIT_VAL, 2**(CTR_W-1), value written to every entry after reset (weakly prefer gp).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
ready  out  1  1 = table initialised, lookups/updates accepted
lookup_valid  in  1  lookup request this cycle
lookup_history  in  HIST_W  global history for lookup
lookup_pc  in  PC_W  branch PC (used only when HASH_MODE=1)
lp_prediction  in  1  local predictor's direction for this lookup
gp_prediction  in  1  global predictor's direction for this lookup
pred_valid  out  1  registered; outputs below are valid
choice_prediction  out  1  1 = use gp, 0 = use lp
final_prediction  out  1  gp_prediction if choice_prediction=1, else lp_prediction (both captured at lookup)
pred_index  out  HIST_W  table index used; the caller returns it on update
update_valid  in  1  resolve a branch
update_index  in  HIST_W  index returned from pred_index
update_lp  in  1  lp direction recorded for that branch
update_gp  in  1  gp direction recorded for that branch
actually_taken  in  1  resolved direction

Behaviour:
- Reset (reset=0, async) clears the following to 0: ready, pred_valid, choice_prediction, final_prediction, pred_index, sweep_ptr. State goes to INIT. Table contents are not reset directly.
- FSM INIT:
  - each cycle writes INIT_VAL to table[sweep_ptr], then sweep_ptr++;
  - after writing DEPTH-1, the next state is RUN;
  - ready rises on the cycle after the last write, so it is low for exactly DEPTH cycles after reset release;
  - lookup_valid and update_valid are ignored; pred_valid stays 0.
- FSM RUN: ready=1; stays in RUN until reset. Reset asserted mid-operation returns to INIT and the sweep restarts from 0.
- Index: idx = lookup_history (HASH_MODE=0) or lookup_history ^ lookup_pc[HIST_W-1:0] (HASH_MODE=1).
- Lookup latency is 1 cycle. On an edge with lookup_valid=1 in RUN:
  - pred_valid<=1, pred_index<=idx;
  - choice_prediction<=(ctr >= INIT_VAL), where ctr is the effective counter value;
  - final_prediction<= choice ? gp_prediction : lp_prediction.
  - If lookup_valid=0, pred_valid<=0 and the other outputs hold their previous values.
- Update, on an edge with update_valid=1 in RUN (c = table[update_index]):
  - count_up = (update_gp==actually_taken) && (update_lp!=actually_taken); c<=c+1, saturating at 2**CTR_W-1.
  - count_down = (update_lp==actually_taken) && (update_gp!=actually_taken); c<=c-1, saturating at 0.
  - Otherwise (both right or both wrong) no write.
- Bypass: lookup and update to the same index on the same edge means the lookup uses the post-update counter value. An update never alters an already-registered prediction.
- Only one update per cycle; no update queueing.
- Counter arithmetic is CTR_W-bit unsigned; the saturation check happens before the add, so no wrap-around.

Test Plan:
1. Defaults. Release reset, hold lookup_valid=1 → ready=0 and pred_valid=0 for 4096 cycles. Then ready=1, and every index reads choice_prediction=1 (ctr=4).
2. Saturate down. Four updates at idx 5 with update_lp=1, update_gp=0, taken=1 → ctr 4→0. Lookup hist=5, lp=1, gp=0 → choice=0, final=1. A fifth update keeps ctr at 0 (next up-update gives 1, not wrap).
3. Saturate up. Three updates at idx 20 with gp correct, lp wrong → ctr=7. Fourth update → still 7. Both-correct and both-wrong updates → ctr unchanged.
4. Bypass. ctr[9]=4. On the same edge: down-update idx 9 and lookup hist=9 → choice_prediction=0 the next cycle (ctr 3). Lookup hist=9 on cycle N then down-update on N+1 → the cycle-N+1 output still shows choice=1.
5. Hash. HASH_MODE=1, HIST_W=8, history=0x0F, pc=0x3F0 → pred_index=0xFF. HASH_MODE=0 with the same stimulus → pred_index=0x0F.
6. Reset mid-run. Assert reset during RUN for 1 cycle → ready=0 immediately and asynchronously. After DEPTH cycles an entry previously at 7 reads INIT_VAL.
